// File: rtl/knight_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package knight_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned MOVE_W = 8;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned RESP_W = 8;

  localparam logic [3:0] OP_VERT = 4'h2;
  localparam logic [3:0] OP_HORZ = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [RESP_W-1:0] RESP_DONE = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_LEG  = 8'h5A;
  localparam logic [RESP_W-1:0] RESP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERT,
    ST_WAIT_V,
    ST_HORZ,
    ST_WAIT_H
  } state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] heading;
    logic [3:0] squares;
  } cmd_t;

  function automatic cmd_t mk_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                  input logic [3:0] sq);
    cmd_t c;
    c.opcode  = op;
    c.heading = hdg;
    c.squares = sq;
    return c;
  endfunction

  function automatic logic is_one_hot(input logic [MOVE_W-1:0] v);
    return (v != '0) && ((v & (v - MOVE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into vertical and horizontal leg commands.
// Lowest set bit wins; an all-zero vector decodes as bit0.
module knight_move_decode
  import knight_pkg::*;
(
  input  logic [MOVE_W-1:0] mv_reg_i,
  output cmd_t              vert_cmd_o,
  output cmd_t              horz_cmd_o
);

  always_comb begin
    vert_cmd_o = mk_cmd(OP_VERT, HDG_N, 4'd2);
    horz_cmd_o = mk_cmd(OP_HORZ, HDG_E, 4'd1);
    casez (mv_reg_i)
      8'b???????1: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_N, 4'd2);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_E, 4'd1);
      end
      8'b??????10: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_N, 4'd2);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_W, 4'd1);
      end
      8'b?????100: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_N, 4'd1);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_W, 4'd2);
      end
      8'b????1000: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_S, 4'd1);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_W, 4'd2);
      end
      8'b???10000: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_S, 4'd2);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_W, 4'd1);
      end
      8'b??100000: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_S, 4'd2);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_E, 4'd1);
      end
      8'b?1000000: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_S, 4'd1);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_E, 4'd2);
      end
      8'b10000000: begin
        vert_cmd_o = mk_cmd(OP_VERT, HDG_N, 4'd1);
        horz_cmd_o = mk_cmd(OP_HORZ, HDG_E, 4'd2);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Command arbiter: UART pass-through in IDLE, knight's-tour leg sequencer otherwise.
// Optional TOUR_MOVE_CHECK_EN aborts the tour on a move that is not one-hot.
module tour_cmd_seq
  import knight_pkg::*;
#(
  parameter int unsigned TOUR_LEN = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tour_go,
  input  logic [MOVE_W-1:0] move,
  output logic [IDX_W-1:0]  mv_indx,
  input  logic [CMD_W-1:0]  cmd_UART,
  input  logic              cmd_rdy_UART,
  output logic              clr_cmd_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy_cp,
  input  logic              send_resp,
  output logic [RESP_W-1:0] resp
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  mv_indx_q, mv_indx_d;
  logic [MOVE_W-1:0] mv_reg_q, mv_reg_d;
  cmd_t              vert_cmd, horz_cmd;
  logic              last_move_c;
  logic              move_ok_c;

  knight_move_decode u_decode (
    .mv_reg_i   (mv_reg_q),
    .vert_cmd_o (vert_cmd),
    .horz_cmd_o (horz_cmd)
  );

  assign last_move_c = (mv_indx_q == IDX_W'(TOUR_LEN - 1));
  assign mv_indx     = mv_indx_q;

`ifdef TOUR_MOVE_CHECK_EN
  assign move_ok_c = is_one_hot(move);
`else
  assign move_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mv_indx_q <= '0;
      mv_reg_q  <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      mv_reg_q  <= mv_reg_d;
    end
  end

  // Next state and interface muxing; legs are driven from the registered move only.
  always_comb begin
    state_d     = state_q;
    mv_indx_d   = mv_indx_q;
    mv_reg_d    = mv_reg_q;
    cmd         = vert_cmd;
    cmd_rdy     = 1'b0;
    clr_cmd_rdy = 1'b0;
    resp        = RESP_LEG;
    case (state_q)
      ST_IDLE: begin
        cmd         = cmd_UART;
        cmd_rdy     = cmd_rdy_UART;
        clr_cmd_rdy = clr_cmd_rdy_cp;
        resp        = RESP_DONE;
        if (tour_go) begin
          state_d   = ST_LOAD;
          mv_indx_d = '0;
        end
      end
      ST_LOAD: begin
        if (move_ok_c) begin
          mv_reg_d = move;
          state_d  = ST_VERT;
        end else begin
          resp    = RESP_ERR;
          state_d = ST_IDLE;
        end
      end
      ST_VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy_cp) state_d = ST_WAIT_V;
      end
      ST_WAIT_V: begin
        if (send_resp) state_d = ST_HORZ;
      end
      ST_HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy_cp) state_d = ST_WAIT_H;
      end
      ST_WAIT_H: begin
        cmd = horz_cmd;
        if (last_move_c) resp = RESP_DONE;
        if (send_resp) begin
          if (last_move_c) begin
            state_d = ST_IDLE;
          end else begin
            mv_indx_d = mv_indx_q + IDX_W'(1);
            state_d   = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq with a four-move tour.
module tb_tour_cmd_seq;

  localparam int unsigned LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tour_go = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_cp = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  logic [7:0]  tbl [LEN];
  logic [15:0] sb [$];
  int          total = 0;
  int          bad = 0;
  int          dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  int          dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

  assign move = tbl[mv_indx[1:0]];

  always #5 clk = ~clk;

  tour_cmd_seq #(.TOUR_LEN(LEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tour_go        (tour_go),
    .move           (move),
    .mv_indx        (mv_indx),
    .cmd_UART       (cmd_UART),
    .cmd_rdy_UART   (cmd_rdy_UART),
    .clr_cmd_rdy    (clr_cmd_rdy),
    .cmd            (cmd),
    .cmd_rdy        (cmd_rdy),
    .clr_cmd_rdy_cp (clr_cmd_rdy_cp),
    .send_resp      (send_resp),
    .resp           (resp)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected legs from the (dy,dx) table; lowest set bit wins, zero means bit0.
  task automatic push_legs(input logic [7:0] mv);
    int b = 0;
    int ady, adx;
    for (int i = 7; i >= 0; i--) if (mv[i]) b = i;
    ady = (dy_t[b] < 0) ? -dy_t[b] : dy_t[b];
    adx = (dx_t[b] < 0) ? -dx_t[b] : dx_t[b];
    sb.push_back({4'h2, (dy_t[b] > 0) ? 8'h00 : 8'h7F, 4'(ady)});
    sb.push_back({4'h3, (dx_t[b] > 0) ? 8'hBF : 8'h3F, 4'(adx)});
  endtask

  task automatic run_tour(input bit combo_ack, input bit abort_last);
    bit last;
    int n;
    for (int i = 0; i < int'(LEN); i++) push_legs(tbl[i]);
    tour_go = 1'b1;
    step();
    tour_go = 1'b0;
    #1;
    check_eq("load_rdy", 16'(cmd_rdy), 16'h0);
    check_eq("load_idx", 16'(mv_indx), 16'h0);
    step();
    check_eq("vert_latency", 16'(cmd_rdy), 16'h1);
    for (int m = 0; m < int'(LEN); m++) begin
      for (int leg = 0; leg < 2; leg++) begin
        n = 0;
        while (!cmd_rdy && n < 8) begin
          step();
          n++;
        end
        if (!cmd_rdy) begin
          check_eq("rdy_timeout", 16'(cmd_rdy), 16'h1);
          sb.delete();
          return;
        end
        check_eq("leg_cmd", cmd, sb.pop_front());
        check_eq("leg_idx", 16'(mv_indx), 16'(m));
        check_eq("leg_resp", 16'(resp), 16'h005A);
        clr_cmd_rdy_cp = 1'b1;
        send_resp = combo_ack && (leg == 0);
        #1;
        check_eq("uart_ack_blocked", 16'(clr_cmd_rdy), 16'h0);
        step();
        clr_cmd_rdy_cp = 1'b0;
        send_resp = 1'b0;
        #1;
        last = (m == int'(LEN) - 1) && (leg == 1);
        check_eq("wait_rdy", 16'(cmd_rdy), 16'h0);
        check_eq("wait_resp", 16'(resp), last ? 16'h00A5 : 16'h005A);
        if (combo_ack && leg == 0) begin
          step();
          check_eq("stale_resp_dropped", 16'(cmd_rdy), 16'h0);
        end
        if (abort_last && last) begin
          cmd_rdy_UART = 1'b1;
          rst_n = 1'b0;
          #1;
          check_eq("rst_idx", 16'(mv_indx), 16'h0);
          check_eq("rst_rdy", 16'(cmd_rdy), 16'h1);
          check_eq("rst_resp", 16'(resp), 16'h00A5);
          step();
          rst_n = 1'b1;
          step();
          check_eq("post_rst_idle", 16'(cmd_rdy), 16'h1);
          cmd_rdy_UART = 1'b0;
          #1;
          check_eq("post_rst_follow", 16'(cmd_rdy), 16'h0);
          sb.delete();
          return;
        end
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
      end
    end
    #1;
    check_eq("end_resp", 16'(resp), 16'h00A5);
    check_eq("end_idx", 16'(mv_indx), 16'(LEN - 1));
  endtask

  initial begin
    tbl = '{8'h01, 8'h08, 8'h80, 8'h10};
    cmd_UART = 16'h2002;
    cmd_rdy_UART = 1'b1;
    #2 rst_n = 1'b0;
    #5;
    check_eq("reset_idx", 16'(mv_indx), 16'h0);
    check_eq("reset_resp", 16'(resp), 16'h00A5);
    check_eq("reset_rdy", 16'(cmd_rdy), 16'h1);
    step();
    rst_n = 1'b1;
    step();

    // Pass-through in IDLE
    clr_cmd_rdy_cp = 1'b1;
    #1;
    check_eq("pt_cmd", cmd, 16'h2002);
    check_eq("pt_clr", 16'(clr_cmd_rdy), 16'h1);
    check_eq("pt_resp", 16'(resp), 16'h00A5);
    step();
    clr_cmd_rdy_cp = 1'b0;
    cmd_rdy_UART = 1'b0;

    run_tour(1'b0, 1'b0);

    // UART command held pending across a tour, with ack+resp collisions
    tbl = '{8'h02, 8'h04, 8'h20, 8'h40};
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    run_tour(1'b1, 1'b0);
    check_eq("uart_pending_cmd", cmd, 16'h1234);
    check_eq("uart_pending_rdy", 16'(cmd_rdy), 16'h1);
    check_eq("uart_no_early_ack", 16'(clr_cmd_rdy), 16'h0);
    clr_cmd_rdy_cp = 1'b1;
    #1;
    check_eq("uart_ack", 16'(clr_cmd_rdy), 16'h1);
    step();
    clr_cmd_rdy_cp = 1'b0;
    cmd_rdy_UART = 1'b0;

    // Async reset in the final WAIT_H
    tbl = '{8'h01, 8'h01, 8'h01, 8'h01};
    run_tour(1'b0, 1'b1);

    tbl = '{8'h03, 8'h00, 8'h06, 8'h81};
`ifdef TOUR_MOVE_CHECK_EN
    tour_go = 1'b1;
    step();
    tour_go = 1'b0;
    #1;
    check_eq("chk_err_resp", 16'(resp), 16'h00EE);
    check_eq("chk_err_rdy", 16'(cmd_rdy), 16'h0);
    step();
    check_eq("chk_idle_resp", 16'(resp), 16'h00A5);
    check_eq("chk_idle_idx", 16'(mv_indx), 16'h0);
    step();
    check_eq("chk_no_cmd", 16'(cmd_rdy), 16'h0);
`else
    run_tour(1'b0, 1'b0);
`endif

    check_eq("sb_empty", 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
